// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag bit positions and stage occupancy encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_BSUBA = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_PASSB = 4'b1101;
    localparam logic [3:0] OP_ANDN  = 4'b1010;
    localparam logic [3:0] OP_ORN   = 4'b1011;
    localparam logic [3:0] OP_XNOR  = 4'b1110;
    localparam logic [3:0] OP_NOTB  = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} generation from ALU operands, opcode and result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    logic add_c;
    logic add_v;
    logic sub_c;
    logic sub_v;
    logic rsb_c;
    logic rsb_v;
    logic c;
    logic v;

    // a+b carries out exactly when b exceeds the headroom ~a
    assign add_c = (b > ~a);
    assign add_v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
    assign sub_c = (a >= b);
    assign sub_v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
    assign rsb_c = (b >= a);
    assign rsb_v = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);

    always_comb begin
        c = 1'b0;
        v = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                c = add_c;
                v = add_v;
            end
            (op == OP_SUB): begin
                c = sub_c;
                v = sub_v;
            end
            (op == OP_BSUBA): begin
                c = rsb_c;
                v = rsb_v;
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result capture stage: flag generation plus 2-entry skid buffer.
// Define ALU_RESULT_STAGE_FWD_EN to expose head-entry bypass ports.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [3:0]        out_flags
`ifdef ALU_RESULT_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic [3:0]        flags;
    } entry_t;

    cnt_e   count_q;
    cnt_e   count_d;
    entry_t e0_q;
    entry_t e0_d;
    entry_t e1_q;
    entry_t e1_d;
    entry_t cap;
    logic   rdy_q;
    logic   in_fire;
    logic   out_fire;
    logic [3:0] cap_flags;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flags (
        .a      (in_a),
        .b      (in_b),
        .op     (in_op),
        .result (in_result),
        .flags  (cap_flags)
    );

    always_comb begin
        cap.result = in_result;
        cap.rd     = in_rd;
        cap.we     = in_we;
        cap.flags  = cap_flags;
    end

    assign out_valid = (count_q != EMPTY);
    assign in_ready  = rdy_q;
    assign in_fire   = in_valid && rdy_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        unique case (count_q)
            EMPTY: begin
                if (in_fire) begin
                    e0_d    = cap;
                    count_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    e0_d = cap;
                end else if (in_fire) begin
                    e1_d    = cap;
                    count_d = FULL;
                end else if (out_fire) begin
                    count_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    e0_d    = e1_q;
                    count_d = ONE;
                end
            end
            default: begin
                count_d = EMPTY;
            end
        endcase
    end

    // in_ready comes from a flop so out_ready never reaches upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= EMPTY;
            rdy_q   <= 1'b1;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            rdy_q   <= (count_d != FULL);
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign out_result = e0_q.result;
    assign out_rd     = e0_q.rd;
    assign out_we     = e0_q.we;
    assign out_flags  = e0_q.flags;

`ifdef ALU_RESULT_STAGE_FWD_EN
    assign fwd_valid = out_valid && e0_q.we && (e0_q.rd != '0);
    assign fwd_rd    = e0_q.rd;
    assign fwd_data  = e0_q.result;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [3:0]  out_flags;
`ifdef ALU_RESULT_STAGE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int failures = 0;

    alu_result_stage #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_flags  (out_flags)
`ifdef ALU_RESULT_STAGE_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] r,
                         input logic [4:0] rd,
                         input logic we);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_result = r;
        in_rd     = rd;
        in_we     = we;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_result = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_we", 32'(out_we), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // add with carry-out to zero
        out_ready = 1'b1;
        drive(4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd3, 1'b1);
        step();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", out_result, 32'h0);
        chk("add_flags", 32'(out_flags), 32'b0110);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_we", 32'(out_we), 32'd1);
        step();
        chk("add_drained", 32'(out_valid), 32'd0);

        // a-b signed overflow
        drive(4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 5'd4, 1'b1);
        step();
        in_valid = 1'b0;
        chk("sub_result", out_result, 32'h7FFFFFFF);
        chk("sub_flags", 32'(out_flags), 32'b0011);
        step();

        // b-a with borrow
        drive(4'b0101, 32'd5, 32'd3, 32'hFFFFFFFE, 5'd5, 1'b0);
        step();
        in_valid = 1'b0;
        chk("bsuba_flags", 32'(out_flags), 32'b1000);
        chk("bsuba_we", 32'(out_we), 32'd0);
        step();

        // logic op never reports carry/overflow
        drive(4'b1000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 5'd6, 1'b1);
        step();
        in_valid = 1'b0;
        chk("and_flags", 32'(out_flags), 32'b1000);
        step();

        // add with signed overflow, no carry
        drive(4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'd1, 1'b1);
        step();
        in_valid = 1'b0;
        chk("addv_flags", 32'(out_flags), 32'b1001);
        step();

        // backpressure: three inputs, two accepted
        out_ready = 1'b0;
        drive(4'b1101, 32'h0, 32'h100, 32'h100, 5'd10, 1'b1);
        step();
        chk("bp1_in_ready", 32'(in_ready), 32'd1);
        chk("bp1_result", out_result, 32'h100);
        drive(4'b1101, 32'h0, 32'h101, 32'h101, 5'd11, 1'b1);
        step();
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        chk("bp2_result", out_result, 32'h100);
        drive(4'b1101, 32'h0, 32'h102, 32'h102, 5'd12, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp3_in_ready", 32'(in_ready), 32'd0);
        chk("bp3_valid", 32'(out_valid), 32'd1);
        chk("bp3_result", out_result, 32'h100);
        chk("bp3_rd", 32'(out_rd), 32'd10);
        out_ready = 1'b1;
        step();
        chk("dr1_in_ready", 32'(in_ready), 32'd1);
        chk("dr1_result", out_result, 32'h101);
        chk("dr1_rd", 32'(out_rd), 32'd11);
        step();
        chk("dr2_valid", 32'(out_valid), 32'd0);

        // streaming at full rate
        for (int i = 0; i < 16; i++) begin
            drive(4'b1101, 32'h0, 32'h200 + i, 32'h200 + i, 5'(i), 1'b1);
            step();
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_result", out_result, 32'h200 + i);
            chk("st_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("st_end_valid", 32'(out_valid), 32'd0);

        // reset while full
        out_ready = 1'b0;
        drive(4'b1101, 32'h0, 32'h300, 32'h300, 5'd2, 1'b1);
        step();
        step();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rfull_valid", 32'(out_valid), 32'd0);
        chk("rfull_in_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rfull_post_valid", 32'(out_valid), 32'd0);
        chk("rfull_post_result", out_result, 32'd0);

`ifdef ALU_RESULT_STAGE_FWD_EN
        out_ready = 1'b1;
        drive(4'b1101, 32'h0, 32'h55, 32'h55, 5'd0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("fwd_rd0_valid", 32'(fwd_valid), 32'd0);
        step();
        drive(4'b1101, 32'h0, 32'h1234, 32'h1234, 5'd7, 1'b1);
        step();
        in_valid = 1'b0;
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_rd", 32'(fwd_rd), 32'd7);
        chk("fwd_data", fwd_data, 32'h1234);
        step();
        chk("fwd_idle", 32'(fwd_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 32-bit ALU. Captures the ALU Result together with its operands, opcode and destination tag.
- Derives zero/negative/carry/overflow flags and holds everything in a 2-entry skid buffer.
- Presents the entries to writeback over a valid/ready handshake.
- Decouples ALU timing from writeback stalls without combinational ready paths upstream.

Parameters:
- DATA_W, 32, datapath width; must match the ALU operand/Result width.
- REG_AW, 5, destination register address width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  stage can accept; registered output, high when at least one skid entry is free.
- in_a  input  DATA_W  ALU operand a.
- in_b  input  DATA_W  ALU operand b.
- in_op  input  4  ALU operation code.
- in_result  input  DATA_W  ALU Result.
- in_rd  input  REG_AW  destination register.
- in_we  input  1  register write enable.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts the head entry.
- out_result  output  DATA_W  head Result.
- out_rd  output  REG_AW  head destination.
- out_we  output  1  head write enable.
- out_flags  output  4  {N, Z, C, V} of the head entry.

Behaviour:
- Reset (async assert, sync deassert handled externally): count=0, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_we=0, out_flags=0.
- Reset mid-operation discards both entries.
- Transfer-in: in_valid && in_ready at a clk edge. Transfer-out: out_valid && out_ready at a clk edge.
- Storage: entry0 is the head (drives outputs), entry1 is the skid. State is count ∈ {EMPTY=0, ONE=1, FULL=2}.
  - EMPTY: in → ONE; write entry0.
  - ONE, in only → FULL; write entry1.
  - ONE, out only → EMPTY.
  - ONE, in and out → ONE; new data goes to entry0.
  - FULL, out → ONE; entry1 shifts to entry0.
  - FULL never accepts input, because in_ready=0.
- in_ready = (count != FULL), registered. No combinational path from out_ready to in_ready.
- Latency: 1 cycle from transfer-in to out_valid when EMPTY. Throughput is 1/cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, all out_* are held constant.
- Flags are computed at capture from in_* and stored per entry:
  - Z = (in_result == 0).
  - N = in_result[DATA_W-1].
  - op 0000 (a+b): C = carry-out of the DATA_W+1-bit sum. V = a,b same sign and result sign differs.
  - op 0110 (a-b): C = (a >= b unsigned), i.e. no borrow. V = a,b sign differ and result sign != a sign.
  - op 0101 (b-a): same as 0110 with a and b swapped.
  - All other opcodes, including undefined ones: C=0, V=0.
- in_result is trusted as given. The stage does not recompute the ALU Result; it only uses in_a/in_b for C/V.
- in_we=0 entries still flow through the buffer normally.

Optional Feature:
- Macro ALU_RESULT_STAGE_FWD_EN.
- When defined, adds three output ports:
  - fwd_valid (1) = out_valid && out_we && (out_rd != 0).
  - fwd_rd (REG_AW) = out_rd.
  - fwd_data (DATA_W) = out_result.
- These are used for bypass to the operand-select stage. They are combinational from the head registers, with zero added latency.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams: OP_ADD=4'b0000, OP_BSUBA=4'b0101, OP_SUB=4'b0110, OP_AND=4'b1000, OP_OR=4'b1001, OP_XOR=4'b1100, OP_PASSB=4'b1101, OP_ANDN=4'b1010, OP_ORN=4'b1011, OP_XNOR=4'b1110, OP_NOTB=4'b1111.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module alu_flag_gen (inputs a, b, op, result; output flags[3:0]), instantiated once on the input path.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, out_flags=0; assert rst_n=0 while FULL → next cycle count=0, in_ready=1.
- op=0000, a=32'hFFFFFFFF, b=1, result=0, rd=3, we=1, out_ready=1 → one cycle later out_valid=1, out_result=0, out_flags={N0,Z1,C1,V0}.
- op=0110, a=32'h80000000, b=1, result=32'h7FFFFFFF → flags {N0,Z0,C1,V1}; op=0101, a=5, b=3, result=32'hFFFFFFFE → {N1,Z0,C0,V0}.
- out_ready=0 with 3 back-to-back inputs → first two accepted, in_ready=0 after the second, outputs frozen on the first; raise out_ready → entries drain in order, in_ready returns to 1 after the first drain.
- Continuous in_valid and out_ready for 16 cycles with incrementing results → 16 outputs in order, no bubbles after the first, in_ready stays 1.
- With ALU_RESULT_STAGE_FWD_EN: head rd=0, we=1 → fwd_valid=0; rd=7, we=1, result=32'h1234 → fwd_valid=1, fwd_rd=7, fwd_data=32'h1234.
